// File: rtl/task_dispatch_stage_pkg.sv
// Shared sizes and the dispatch FIFO entry type for the task dispatch stage.
// Source count and index width are fixed by the 16-input arbiter tree.
package task_dispatch_stage_pkg;

  localparam int SRC_N         = 16;
  localparam int IDX_W         = 4;
  localparam int TASK_W        = 8;
  localparam int DEPTH_DEFAULT = 4;

  typedef struct packed {
    logic [IDX_W-1:0]  src;
    logic [TASK_W-1:0] task_id;
  } disp_entry_t;

endpackage

// File: rtl/dispatch_fifo.sv
// Synchronous dispatch FIFO holding {source, task_id} entries.
// Head data reads as zero while empty so the dispatch outputs idle at zero.
module dispatch_fifo
  import task_dispatch_stage_pkg::*;
#(
  parameter  int DEPTH = DEPTH_DEFAULT,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           push,
  input  logic           pop,
  input  disp_entry_t    wr_data,
  output disp_entry_t    rd_data,
  output logic           full,
  output logic           empty,
  output logic [PTR_W:0] count
);

  disp_entry_t      mem_r [DEPTH];
  logic [PTR_W-1:0] wr_ptr_r;
  logic [PTR_W-1:0] rd_ptr_r;
  logic [PTR_W:0]   count_r;
  logic             push_s;
  logic             pop_s;

  assign full   = (count_r == (PTR_W+1)'(DEPTH));
  assign empty  = (count_r == {(PTR_W+1){1'b0}});
  assign count  = count_r;
  assign push_s = push & ~full;
  assign pop_s  = pop & ~empty;

  // Head data, forced to zero while the FIFO holds nothing.
  always_comb begin
    rd_data = {$bits(disp_entry_t){1'b0}};
    if (!empty) begin
      rd_data = mem_r[rd_ptr_r];
    end else begin
      rd_data = {$bits(disp_entry_t){1'b0}};
    end
  end

  // Storage, pointers and occupancy; pointers wrap naturally at DEPTH.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      count_r  <= {(PTR_W+1){1'b0}};
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= {$bits(disp_entry_t){1'b0}};
      end
    end else begin
      if (push_s) begin
        mem_r[wr_ptr_r] <= wr_data;
        wr_ptr_r        <= wr_ptr_r + PTR_W'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + (PTR_W+1)'(1);
        2'b01:   count_r <= count_r - (PTR_W+1)'(1);
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/task_dispatch_stage.sv
// Latches per-source task requests, feeds them to the round-robin arbiter and
// queues each accepted winner as {source, task_id} for the core dispatcher.
module task_dispatch_stage
  import task_dispatch_stage_pkg::*;
#(
  parameter  int DEPTH = DEPTH_DEFAULT,
  localparam int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [SRC_N-1:0]         src_req,
  input  logic [SRC_N*TASK_W-1:0]  src_task,
  output logic [SRC_N-1:0]         src_busy,
  output logic [SRC_N-1:0]         arb_req,
  input  logic [IDX_W-1:0]         arb_grant_index,
  input  logic                     arb_valid,
  output logic                     disp_valid,
  input  logic                     disp_ready,
  output logic [IDX_W-1:0]         disp_src,
  output logic [TASK_W-1:0]        disp_task,
  output logic                     drop_err
);

  logic [SRC_N-1:0]  pending_r;
  logic [TASK_W-1:0] task_r [SRC_N];
  logic              drop_err_r;
  logic [SRC_N-1:0]  capture_s;
  logic [SRC_N-1:0]  grant_dec_s;
  logic              accept_s;
  logic              fifo_full_s;
  logic              fifo_empty_s;
  logic [CNT_W-1:0]  fifo_count_s;
  disp_entry_t       push_entry_s;
  disp_entry_t       head_s;

  assign accept_s     = arb_valid & ~fifo_full_s;
  assign capture_s    = src_req & ~pending_r;
  assign push_entry_s = '{src: arb_grant_index, task_id: task_r[arb_grant_index]};

  // Masking while full keeps the arbiter's priority state from advancing
  // on grants this stage cannot take.
  assign arb_req = (fifo_count_s < CNT_W'(DEPTH)) ? pending_r : {SRC_N{1'b0}};

  // One-hot clear mask for the accepted winner.
  always_comb begin
    grant_dec_s = {SRC_N{1'b0}};
    if (accept_s) begin
      grant_dec_s[arb_grant_index] = 1'b1;
    end else begin
      grant_dec_s = {SRC_N{1'b0}};
    end
  end

  // Pending bits, latched task ids and the sticky drop flag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pending_r  <= {SRC_N{1'b0}};
      drop_err_r <= 1'b0;
      for (int i = 0; i < SRC_N; i++) begin
        task_r[i] <= {TASK_W{1'b0}};
      end
    end else begin
      // A request on a still-pending source is dropped even if that source
      // is granted on this same edge.
      pending_r  <= (pending_r & ~grant_dec_s) | capture_s;
      drop_err_r <= drop_err_r | (|(src_req & pending_r));
      for (int i = 0; i < SRC_N; i++) begin
        if (capture_s[i]) begin
          task_r[i] <= src_task[i*TASK_W +: TASK_W];
        end
      end
    end
  end

  dispatch_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (accept_s),
    .pop     (disp_valid & disp_ready),
    .wr_data (push_entry_s),
    .rd_data (head_s),
    .full    (fifo_full_s),
    .empty   (fifo_empty_s),
    .count   (fifo_count_s)
  );

  assign src_busy   = pending_r;
  assign disp_valid = ~fifo_empty_s;
  assign disp_src   = head_s.src;
  assign disp_task  = head_s.task_id;
  assign drop_err   = drop_err_r;

endmodule

// File: tb/tb_task_dispatch_stage.sv
// Self-checking bench for task_dispatch_stage with a behavioural round-robin
// arbiter and a scoreboard queue of expected {source, task_id} dispatches.
module tb_task_dispatch_stage;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic [15:0]  src_req = 16'h0000;
  logic [127:0] src_task = 128'h0;
  logic [15:0]  src_busy;
  logic [15:0]  arb_req;
  logic [3:0]   arb_grant_index;
  logic         arb_valid;
  logic         disp_valid;
  logic         disp_ready = 1'b0;
  logic [3:0]   disp_src;
  logic [7:0]   disp_task;
  logic         drop_err;

  int n_cmp = 0;
  int n_err = 0;
  logic [11:0] exp_q[$];
  logic [3:0]  last_r;

  task_dispatch_stage #(.DEPTH(4)) dut (
    .clk(clk), .rst(rst), .src_req(src_req), .src_task(src_task),
    .src_busy(src_busy), .arb_req(arb_req), .arb_grant_index(arb_grant_index),
    .arb_valid(arb_valid), .disp_valid(disp_valid), .disp_ready(disp_ready),
    .disp_src(disp_src), .disp_task(disp_task), .drop_err(drop_err)
  );

  always #5 clk = ~clk;

  // Reference round-robin arbiter: first requester after the last winner.
  always_comb begin
    arb_valid = 1'b0;
    arb_grant_index = 4'd0;
    for (int k = 1; k <= 16; k++) begin
      if (!arb_valid && arb_req[(int'(last_r) + k) % 16]) begin
        arb_valid = 1'b1;
        arb_grant_index = 4'((int'(last_r) + k) % 16);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) last_r <= 4'd15;
    else if (arb_valid) last_r <= arb_grant_index;
  end

  // Expected dispatch order for a set of simultaneous requests.
  function automatic void push_order(input logic [15:0] mask, input logic [3:0] last,
                                     input logic [127:0] tasks);
    for (int k = 1; k <= 16; k++) begin
      int j;
      j = (int'(last) + k) % 16;
      if (mask[j]) exp_q.push_back({4'(j), tasks[j*8 +: 8]});
    end
  endfunction

  task automatic test_reset();
    rst = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      n_cmp++;
      if ({disp_valid, disp_src, disp_task, drop_err, src_busy, arb_req} !== 46'h0) begin
        n_err++;
        $display("FAIL reset_idle cycle %0d: got v=%b src=%h task=%h drop=%b busy=%h req=%h, want all 0",
                 c, disp_valid, disp_src, disp_task, drop_err, src_busy, arb_req);
      end
    end
  endtask

  task automatic test_single();
    logic [11:0] e;
    disp_ready = 1'b1;
    src_req = 16'h0020;
    src_task[5*8 +: 8] = 8'h3A;
    exp_q.push_back({4'd5, 8'h3A});
    @(negedge clk);
    src_req = 16'h0000;
    n_cmp++;
    if (src_busy !== 16'h0020 || arb_req !== 16'h0020) begin
      n_err++;
      $display("FAIL single_busy: busy=%h req=%h, want 0020/0020", src_busy, arb_req);
    end
    @(negedge clk);
    e = exp_q.pop_front();
    n_cmp++;
    if (disp_valid !== 1'b1 || {disp_src, disp_task} !== e) begin
      n_err++;
      $display("FAIL single_dispatch: v=%b entry=%h, want 1/%h", disp_valid, {disp_src, disp_task}, e);
    end
    n_cmp++;
    if (src_busy !== 16'h0000) begin
      n_err++;
      $display("FAIL single_clear: busy=%h, want 0000", src_busy);
    end
    @(negedge clk);
    n_cmp++;
    if (disp_valid !== 1'b0) begin
      n_err++;
      $display("FAIL single_drain: v=%b, want 0", disp_valid);
    end
  endtask

  task automatic test_all_sources();
    int got_n, first_c, last_c;
    logic [11:0] e;
    disp_ready = 1'b1;
    for (int i = 0; i < 16; i++) src_task[i*8 +: 8] = 8'h40 + 8'(i);
    src_req = 16'hFFFF;
    push_order(16'hFFFF, last_r, src_task);
    @(negedge clk);
    src_req = 16'h0000;
    n_cmp++;
    if (src_busy !== 16'hFFFF) begin
      n_err++;
      $display("FAIL all16_busy: busy=%h, want ffff", src_busy);
    end
    got_n = 0; first_c = -1; last_c = -1;
    for (int c = 0; c < 40; c++) begin
      if (disp_valid) begin
        if (first_c < 0) first_c = c;
        last_c = c;
        got_n++;
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL all16_extra: got %h, want nothing", {disp_src, disp_task});
        end else begin
          e = exp_q.pop_front();
          if ({disp_src, disp_task} !== e) begin
            n_err++;
            $display("FAIL all16_order: got %h, want %h", {disp_src, disp_task}, e);
          end
        end
      end
      @(negedge clk);
    end
    n_cmp++;
    if (got_n != 16 || last_c - first_c != 15) begin
      n_err++;
      $display("FAIL all16_count: got %0d over %0d cycles, want 16 over 16", got_n, last_c - first_c + 1);
    end
    n_cmp++;
    if (drop_err !== 1'b0) begin
      n_err++;
      $display("FAIL all16_drop: drop_err=%b, want 0", drop_err);
    end
  endtask

  task automatic test_backpressure();
    logic [15:0] mask, exp_busy;
    logic [11:0] e;
    int got_n;
    disp_ready = 1'b0;
    mask = 16'h5286;
    for (int i = 0; i < 16; i++) src_task[i*8 +: 8] = 8'h80 + 8'(i);
    src_req = mask;
    push_order(mask, last_r, src_task);
    exp_busy = (16'h0001 << exp_q[4][11:8]) | (16'h0001 << exp_q[5][11:8]);
    @(negedge clk);
    src_req = 16'h0000;
    repeat (6) @(negedge clk);
    n_cmp++;
    if (src_busy !== exp_busy || arb_req !== 16'h0000) begin
      n_err++;
      $display("FAIL full_mask: busy=%h req=%h, want %h/0000", src_busy, arb_req, exp_busy);
    end
    for (int c = 0; c < 3; c++) begin
      n_cmp++;
      if (disp_valid !== 1'b1 || {disp_src, disp_task} !== exp_q[0]) begin
        n_err++;
        $display("FAIL full_head_stable: v=%b entry=%h, want 1/%h", disp_valid, {disp_src, disp_task}, exp_q[0]);
      end
      @(negedge clk);
    end
    disp_ready = 1'b1;
    got_n = 0;
    for (int c = 0; c < 30; c++) begin
      if (disp_valid) begin
        got_n++;
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL full_extra: got %h, want nothing", {disp_src, disp_task});
        end else begin
          e = exp_q.pop_front();
          if ({disp_src, disp_task} !== e) begin
            n_err++;
            $display("FAIL full_order: got %h, want %h", {disp_src, disp_task}, e);
          end
        end
      end
      @(negedge clk);
    end
    n_cmp++;
    if (got_n != 6) begin
      n_err++;
      $display("FAIL full_total: got %0d dispatches, want 6", got_n);
    end
  endtask

  task automatic test_drop();
    logic [11:0] e;
    int got_n;
    disp_ready = 1'b1;
    src_req = 16'h0008;
    src_task[3*8 +: 8] = 8'h11;
    exp_q.push_back({4'd3, 8'h11});
    @(negedge clk);
    src_task[3*8 +: 8] = 8'h22;
    n_cmp++;
    if (src_busy !== 16'h0008 || drop_err !== 1'b0) begin
      n_err++;
      $display("FAIL drop_first: busy=%h drop=%b, want 0008/0", src_busy, drop_err);
    end
    @(negedge clk);
    src_req = 16'h0000;
    got_n = 0;
    for (int c = 0; c < 10; c++) begin
      if (disp_valid) begin
        got_n++;
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL drop_extra: got %h, want nothing", {disp_src, disp_task});
        end else begin
          e = exp_q.pop_front();
          if ({disp_src, disp_task} !== e) begin
            n_err++;
            $display("FAIL drop_task: got %h, want %h", {disp_src, disp_task}, e);
          end
        end
      end
      n_cmp++;
      if (drop_err !== 1'b1) begin
        n_err++;
        $display("FAIL drop_sticky cycle %0d: drop_err=%b, want 1", c, drop_err);
      end
      @(negedge clk);
    end
    n_cmp++;
    if (got_n != 1 || src_busy !== 16'h0000) begin
      n_err++;
      $display("FAIL drop_count: got %0d dispatches busy=%h, want 1/0000", got_n, src_busy);
    end
  endtask

  task automatic test_reset_mid();
    disp_ready = 1'b0;
    src_req = 16'h0007;
    @(negedge clk);
    src_req = 16'h0000;
    repeat (4) @(negedge clk);
    n_cmp++;
    if (disp_valid !== 1'b1 || src_busy !== 16'h0000) begin
      n_err++;
      $display("FAIL rstmid_setup: v=%b busy=%h, want 1/0000", disp_valid, src_busy);
    end
    src_req = 16'hF800;
    @(negedge clk);
    src_req = 16'h0000;
    n_cmp++;
    if (src_busy !== 16'hF800) begin
      n_err++;
      $display("FAIL rstmid_pending: busy=%h, want f800", src_busy);
    end
    rst = 1'b0;
    #1;
    n_cmp++;
    if ({disp_valid, src_busy, arb_req, drop_err, disp_src, disp_task} !== 46'h0) begin
      n_err++;
      $display("FAIL rstmid_async: v=%b busy=%h req=%h drop=%b entry=%h, want all 0",
               disp_valid, src_busy, arb_req, drop_err, {disp_src, disp_task});
    end
    @(negedge clk);
    rst = 1'b1;
    disp_ready = 1'b1;
    exp_q.delete();
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      n_cmp++;
      if (disp_valid !== 1'b0 || src_busy !== 16'h0000 || arb_req !== 16'h0000) begin
        n_err++;
        $display("FAIL rstmid_after cycle %0d: v=%b busy=%h req=%h, want 0", c, disp_valid, src_busy, arb_req);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_all_sources();
    test_backpressure();
    test_drop();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/task_dispatch_stage.md
# task_dispatch_stage

Downstream consumer and request source for the 16-input round-robin arbiter tree. The block latches per-source task requests and drives them as the arbiter's 16-bit request vector. Each cycle it captures the arbiter's winning index and valid, clears the winner's pending bit, and pushes {source, task_id} into an output FIFO. The FIFO drains to the core-side dispatcher through a valid/ready handshake.

## Interface
Parameters:
- SRC_N, 16, number of request sources; fixed to match the arbiter width
- IDX_W, 4, grant index width (log2 SRC_N)
- TASK_W, 8, task identifier width
- DEPTH, 4, output FIFO depth; power of two, at least 2

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-low reset
- src_req  in  SRC_N  per-source request strobe, sampled each edge
- src_task  in  SRC_N*TASK_W  per-source task id; slice i is valid with src_req[i]
- src_busy  out  SRC_N  pending bit per source
- arb_req  out  SRC_N  request vector to the arbiter
- arb_grant_index  in  IDX_W  arbiter winner (combinational from arb_req)
- arb_valid  in  1  arbiter has a winner
- disp_valid  out  1  FIFO head valid
- disp_ready  in  1  consumer accepts the head
- disp_src  out  IDX_W  head source index
- disp_task  out  TASK_W  head task id
- drop_err  out  1  sticky flag: a request arrived for a busy source

## Operation
- Reset values:
  - pending[*] = 0, task_reg[*] = 0
  - FIFO empty: count = 0, read/write pointers = 0
  - All outputs 0: disp_valid, disp_src, disp_task, drop_err, src_busy, arb_req
- Request capture:
  - On an edge where src_req[i]=1 and pending[i]=0: pending[i] ← 1, task_reg[i] ← src_task slice i.
  - If pending[i]=1 at that edge: the request is dropped, task_reg[i] is unchanged, and drop_err ← 1.
  - drop_err clears only on reset.
- src_busy = pending (registered).
- arb_req = pending when FIFO count < DEPTH; otherwise all zeros. Masking when full prevents the arbiter's priority flops from toggling on grants that cannot be taken, which preserves round-robin fairness.
- Grant accept, on an edge where arb_valid=1 and count < DEPTH:
  - Push {arb_grant_index, task_reg[arb_grant_index]}.
  - Clear pending[arb_grant_index].
- Simultaneous grant and src_req for the same source: the grant clears the bit; src_req sees pending=1 at that edge, so it is dropped and drop_err is set.
- Pop happens on any edge where disp_valid & disp_ready.
- Push and pop may occur on the same edge when count < DEPTH; count is unchanged.
- When count = DEPTH, no push occurs even if a pop happens that same edge. arb_req is already masked in that cycle.
- Pointer and count arithmetic:
  - Pointers are log2(DEPTH) bits and wrap modulo DEPTH.
  - count is log2(DEPTH)+1 bits and never exceeds DEPTH.
- Head outputs disp_src/disp_task stay stable while disp_valid=1 and disp_ready=0.
- Reset assertion mid-operation: all pending requests and FIFO contents are discarded immediately (asynchronous). No dispatch is emitted on the next edge.

## Timing
- src_req[i] high at edge k → pending[i]=1 and arb_req[i]=1 after edge k.
- The grant is captured at edge k+1 (if FIFO not full and i wins), so disp_valid=1 after edge k+1. Minimum latency is 2 edges.
- One grant accepted per cycle; sustained throughput is one dispatch per cycle when disp_ready is held high.
- disp_valid deasserts the edge after the last entry is popped.
- The arbiter path is combinational: arb_req → arb_grant_index/arb_valid → FIFO write enable. That path is the block's critical timing path.

## Structure
- Shared package holds SRC_N, IDX_W, TASK_W, the default DEPTH, and a typedef for the FIFO entry {src, task}.
- One sub-module: dispatch_fifo. It is a synchronous FIFO with push, pop, full, empty and count, using the same clk/rst (active-low, asynchronous).
- Pending/task registers and arb_req masking live in the top level.

## Test plan
- Reset release with src_req=0 → all outputs 0 and arb_req=0 for 10 cycles.
- Single request, source 5 with task 0x3A, disp_ready=1:
  - src_busy[5]=1 after 1 edge.
  - disp_valid=1 with disp_src=5 and disp_task=0x3A after 2 edges.
  - src_busy[5]=0 once the entry is pushed.
- All 16 sources request at once, disp_ready=1 → 16 dispatches on consecutive cycles, each source exactly once, in arbiter round-robin order. No drop_err.
- disp_ready=0 with 6 sources pending, DEPTH=4:
  - Exactly 4 entries are pushed, then arb_req=0.
  - After disp_ready=1, the remaining 2 are dispatched.
  - Total of 6, order preserved.
- Source 3 re-requests while pending (task 0x11 then 0x22) → dispatch carries 0x11 and drop_err=1 stays set until reset.
- rst asserted while FIFO holds 3 entries and 5 sources are pending → disp_valid, src_busy and arb_req go to 0 asynchronously. No dispatch occurs after release.
